// File: rtl/srambank_req_ctrl_256x4x72_if.sv
// Bus bundle for the srambank request controller.
// Groups the request channel, the response channel and the bank-side signals.
//   req_valid/req_ready/req_write/req_addr/req_wdata : request handshake and payload
//   rsp_valid/rsp_ready/rsp_rdata                    : read-data return handshake
//   sram_banksel/read/write/address/wd               : controls driven to the bank
//   sram_dataout                                     : read data coming back from the bank
// Modports:
//   slave  : the controller (consumes requests, drives the bank)
//   master : its environment (requester, response consumer and the bank macro)
interface srambank_req_ctrl_256x4x72_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 72
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              sram_banksel;
  logic              sram_read;
  logic              sram_write;
  logic [ADDR_W-1:0] sram_address;
  logic [DATA_W-1:0] sram_wd;
  logic [DATA_W-1:0] sram_dataout;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, sram_dataout,
    output req_ready, rsp_valid, rsp_rdata,
    output sram_banksel, sram_read, sram_write, sram_address, sram_wd
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, sram_dataout,
    input  req_ready, rsp_valid, rsp_rdata,
    input  sram_banksel, sram_read, sram_write, sram_address, sram_wd
  );
endinterface

// File: rtl/srambank_req_ctrl_256x4x72.sv
// Request front-end for one srambank_256x4x72_6t122 macro.
// Requests are buffered in a small FIFO and issued to the bank one per cycle in
// strict order. Read data from the bank is captured one cycle after the read is
// issued and returned in order through a backpressured response FIFO. A read is
// only issued when a response slot is guaranteed to be free on its return.
// Ports:
//   clk     : single clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of srambank_req_ctrl_256x4x72_if (request, response, bank)
module srambank_req_ctrl_256x4x72 #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 72,
  parameter int REQ_DEPTH = 2,
  parameter int RSP_DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  srambank_req_ctrl_256x4x72_if.slave bus
);
  localparam int RQ_AW = $clog2(REQ_DEPTH);
  localparam int RS_AW = $clog2(RSP_DEPTH);

  // Request FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic              rq_wr_mem   [REQ_DEPTH];
  logic [ADDR_W-1:0] rq_addr_mem [REQ_DEPTH];
  logic [DATA_W-1:0] rq_data_mem [REQ_DEPTH];
  logic [RQ_AW:0]    rq_wptr, rq_rptr;
  logic              rq_full, rq_empty, rq_push;

  // Response FIFO storage and pointers
  logic [DATA_W-1:0] rs_mem [RSP_DEPTH];
  logic [RS_AW:0]    rs_wptr, rs_rptr, rs_count;
  logic              rs_empty, rs_push, rs_pop;

  logic              rd_pending;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [RS_AW+1:0]  credit_used;
  logic              credit_ok, issue;

  assign rq_full  = (rq_wptr[RQ_AW] != rq_rptr[RQ_AW]) &&
                    (rq_wptr[RQ_AW-1:0] == rq_rptr[RQ_AW-1:0]);
  assign rq_empty = (rq_wptr == rq_rptr);
  assign rq_push  = bus.req_valid && !rq_full;

  assign head_write = rq_wr_mem[rq_rptr[RQ_AW-1:0]];
  assign head_addr  = rq_addr_mem[rq_rptr[RQ_AW-1:0]];
  assign head_data  = rq_data_mem[rq_rptr[RQ_AW-1:0]];

  assign rs_empty = (rs_wptr == rs_rptr);
  assign rs_count = rs_wptr - rs_rptr;
  assign rs_pop   = !rs_empty && bus.rsp_ready;
  assign rs_push  = rd_pending;

  // Response slots already claimed: stored entries plus the read in flight,
  // minus the entry leaving this cycle. Counting the departing entry lets
  // back-to-back reads stream at one per cycle while the consumer keeps up;
  // the freed slot is still guaranteed free when the new read data lands.
  assign credit_used = {1'b0, rs_count}
                     + {{(RS_AW+1){1'b0}}, rd_pending}
                     - {{(RS_AW+1){1'b0}}, rs_pop};
  assign credit_ok   = credit_used < (RS_AW+2)'(RSP_DEPTH);

  // Writes never need response space; a blocked read holds everything behind it.
  assign issue = !rq_empty && (head_write || credit_ok);

  assign bus.req_ready    = !rq_full;
  assign bus.rsp_valid    = !rs_empty;
  assign bus.rsp_rdata    = rs_mem[rs_rptr[RS_AW-1:0]];
  assign bus.sram_banksel = issue;
  assign bus.sram_write   = issue && head_write;
  assign bus.sram_read    = issue && !head_write;
  assign bus.sram_address = head_addr;
  assign bus.sram_wd      = head_data;

  always_ff @(posedge clk) begin
    if (rq_push) begin
      rq_wr_mem[rq_wptr[RQ_AW-1:0]]   <= bus.req_write;
      rq_addr_mem[rq_wptr[RQ_AW-1:0]] <= bus.req_addr;
      rq_data_mem[rq_wptr[RQ_AW-1:0]] <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rs_push) begin
      rs_mem[rs_wptr[RS_AW-1:0]] <= bus.sram_dataout;
    end
  end

  // Bank dataout is valid the cycle after a read is issued; rd_pending marks
  // that cycle so the data is captured exactly once. Reset drops it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rq_wptr    <= '0;
      rq_rptr    <= '0;
      rs_wptr    <= '0;
      rs_rptr    <= '0;
      rd_pending <= 1'b0;
    end else begin
      if (rq_push) rq_wptr <= rq_wptr + 1'b1;
      if (issue)   rq_rptr <= rq_rptr + 1'b1;
      if (rs_push) rs_wptr <= rs_wptr + 1'b1;
      if (rs_pop)  rs_rptr <= rs_rptr + 1'b1;
      rd_pending <= issue && !head_write;
    end
  end
endmodule
